// File: rtl/fighter_action_fsm.sv
// Per-fighter action sequencer: movement, timed attacks, hit/block resolution
// and the clamped sprite x position for one player.
module fighter_action_fsm #(
    parameter bit          IS_MIRRORED  = 1'b0,
    parameter logic [9:0]  START_X      = 10'd100,
    parameter logic [9:0]  X_MIN        = 10'd0,
    parameter logic [9:0]  X_MAX        = 10'd576,
    parameter int unsigned MOVE_STEP    = 2,
    parameter int unsigned ATK_STARTUP  = 4,
    parameter int unsigned ATK_ACTIVE   = 2,
    parameter int unsigned ATK_RECOVERY = 8,
    parameter int unsigned DIR_STARTUP  = 6,
    parameter int unsigned DIR_ACTIVE   = 3,
    parameter int unsigned DIR_RECOVERY = 12,
    parameter int unsigned HITSTUN      = 16,
    parameter int unsigned BLOCKSTUN    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic [9:0] opp_hitbox_x1,
    input  logic [9:0] opp_hitbox_x2,
    input  logic [9:0] opp_hitbox_y1,
    input  logic [9:0] opp_hitbox_y2,
    input  logic       opp_hitbox_active,
    input  logic [9:0] hurtbox_x1,
    input  logic [9:0] hurtbox_x2,
    input  logic [9:0] hurtbox_y1,
    input  logic [9:0] hurtbox_y2,
    output logic [3:0] state,
    output logic [9:0] sprite_x,
    output logic       hit_taken,
    output logic       blocked
);

    localparam int unsigned XW = 10;
    localparam int unsigned CW = 5;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_MOVE_FWD   = 4'd1,
        ST_MOVE_BACK  = 4'd2,
        ST_ATK_START  = 4'd3,
        ST_ATK_ACTIVE = 4'd4,
        ST_ATK_RECOV  = 4'd5,
        ST_DIR_START  = 4'd6,
        ST_DIR_ACTIVE = 4'd7,
        ST_DIR_RECOV  = 4'd8,
        ST_HITSTUN    = 4'd9,
        ST_BLOCKSTUN  = 4'd10
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic            hit_q, hit_d;
    logic            blk_q, blk_d;
    logic            atk_prev_q;

    logic            fwd_raw, back_raw, fwd, back, atk_edge, overlap;
    logic            is_free, is_timed, move_pos;
    logic [XW:0]     x_up;

    // Facing-relative direction decode; opposing buttons cancel out
    assign fwd_raw  = IS_MIRRORED ? btn_left  : btn_right;
    assign back_raw = IS_MIRRORED ? btn_right : btn_left;
    assign fwd      = fwd_raw  & ~back_raw;
    assign back     = back_raw & ~fwd_raw;
    assign atk_edge = btn_attack & ~atk_prev_q;

    assign overlap = opp_hitbox_active
                   && (opp_hitbox_x1 < hurtbox_x2) && (opp_hitbox_x2 > hurtbox_x1)
                   && (opp_hitbox_y1 < hurtbox_y2) && (opp_hitbox_y2 > hurtbox_y1);

    assign is_free  = (state_q == ST_IDLE) || (state_q == ST_MOVE_FWD) || (state_q == ST_MOVE_BACK);
    assign is_timed = (state_q >= ST_ATK_START) && (state_q <= ST_BLOCKSTUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            x_q        <= START_X;
            hit_q      <= 1'b0;
            blk_q      <= 1'b0;
            atk_prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            hit_q   <= hit_d;
            blk_q   <= blk_d;
            if (frame_tick) begin
                atk_prev_q <= btn_attack;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        hit_d    = 1'b0;
        blk_d    = 1'b0;
        move_pos = 1'b0;
        x_up     = (XW+1)'(x_q) + (XW+1)'(MOVE_STEP);
        if (frame_tick) begin
            if (overlap && (is_free || (state_q <= ST_DIR_RECOV))) begin
                if (((state_q == ST_IDLE) || (state_q == ST_MOVE_BACK)) && back) begin
                    state_d = ST_BLOCKSTUN;
                    cnt_d   = CW'(BLOCKSTUN - 1);
                    blk_d   = 1'b1;
                end else begin
                    state_d = ST_HITSTUN;
                    cnt_d   = CW'(HITSTUN - 1);
                    hit_d   = 1'b1;
                end
            end else if (is_free) begin
                if (atk_edge && fwd) begin
                    state_d = ST_DIR_START;
                    cnt_d   = CW'(DIR_STARTUP - 1);
                end else if (atk_edge) begin
                    state_d = ST_ATK_START;
                    cnt_d   = CW'(ATK_STARTUP - 1);
                end else if (fwd) begin
                    state_d = ST_MOVE_FWD;
                end else if (back) begin
                    state_d = ST_MOVE_BACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end else if (is_timed) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (state_q)
                        ST_ATK_START:  begin state_d = ST_ATK_ACTIVE; cnt_d = CW'(ATK_ACTIVE - 1);   end
                        ST_ATK_ACTIVE: begin state_d = ST_ATK_RECOV;  cnt_d = CW'(ATK_RECOVERY - 1); end
                        ST_DIR_START:  begin state_d = ST_DIR_ACTIVE; cnt_d = CW'(DIR_ACTIVE - 1);   end
                        ST_DIR_ACTIVE: begin state_d = ST_DIR_RECOV;  cnt_d = CW'(DIR_RECOVERY - 1); end
                        default:       state_d = ST_IDLE;
                    endcase
                end
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end

            // Step in the facing direction, saturating at the clamp bounds
            if ((state_d == ST_MOVE_FWD) || (state_d == ST_MOVE_BACK)) begin
                move_pos = (state_d == ST_MOVE_FWD) ^ IS_MIRRORED;
                if (move_pos) begin
                    x_d = (x_up > (XW+1)'(X_MAX)) ? X_MAX : x_up[XW-1:0];
                end else if ((XW+1)'(x_q) < ((XW+1)'(X_MIN) + (XW+1)'(MOVE_STEP))) begin
                    x_d = X_MIN;
                end else begin
                    x_d = XW'((XW+1)'(x_q) - (XW+1)'(MOVE_STEP));
                end
            end
        end
    end

    assign state     = state_q;
    assign sprite_x  = x_q;
    assign hit_taken = hit_q;
    assign blocked   = blk_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed scoreboard bench: player A (unmirrored, START_X=1) and player B
// (mirrored, defaults) share the clock, tick and opponent box.
module tb_fighter_action_fsm;

    localparam int unsigned A_START = 1;
    localparam int unsigned B_START = 100;
    localparam int unsigned XMAX    = 576;

    typedef struct {
        string      tag;
        bit         is_b;
        logic [3:0] st;
        logic [9:0] x;
        logic       hit;
        logic       blk;
    } exp_t;

    logic clk = 1'b0;
    logic rst, frame_tick;
    logic bl_a, br_a, ba_a, bl_b, br_b, ba_b;
    logic [9:0] ox1, ox2, oy1, oy2;
    logic       oact;
    logic [9:0] hx1, hx2, hy1, hy2;
    logic [3:0] st_a, st_b;
    logic [9:0] x_a, x_b;
    logic       hit_a, hit_b, blk_a, blk_b;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   xa, xb;

    always #5 clk = ~clk;

    fighter_action_fsm #(.IS_MIRRORED(1'b0), .START_X(10'd1)) u_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(bl_a), .btn_right(br_a), .btn_attack(ba_a),
        .opp_hitbox_x1(ox1), .opp_hitbox_x2(ox2), .opp_hitbox_y1(oy1), .opp_hitbox_y2(oy2),
        .opp_hitbox_active(oact),
        .hurtbox_x1(hx1), .hurtbox_x2(hx2), .hurtbox_y1(hy1), .hurtbox_y2(hy2),
        .state(st_a), .sprite_x(x_a), .hit_taken(hit_a), .blocked(blk_a)
    );

    // B's hurtbox is degenerate so it never gets hit
    fighter_action_fsm #(.IS_MIRRORED(1'b1)) u_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(bl_b), .btn_right(br_b), .btn_attack(ba_b),
        .opp_hitbox_x1(ox1), .opp_hitbox_x2(ox2), .opp_hitbox_y1(oy1), .opp_hitbox_y2(oy2),
        .opp_hitbox_active(oact),
        .hurtbox_x1(10'd0), .hurtbox_x2(10'd0), .hurtbox_y1(10'd0), .hurtbox_y2(10'd0),
        .state(st_b), .sprite_x(x_b), .hit_taken(hit_b), .blocked(blk_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic exp_a(input string tag, input logic [3:0] st, input logic hit, input logic blk);
        exp_t e;
        e.tag = tag; e.is_b = 1'b0; e.st = st; e.x = 10'(xa); e.hit = hit; e.blk = blk;
        sbq.push_back(e);
    endtask

    task automatic exp_b(input string tag, input logic [3:0] st);
        exp_t e;
        e.tag = tag; e.is_b = 1'b1; e.st = st; e.x = 10'(xb); e.hit = 1'b0; e.blk = 1'b0;
        sbq.push_back(e);
    endtask

    // Wait for the next edge, then pop and compare every pending expectation
    task automatic sample();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.tag, "_state"}, e.is_b ? st_b  : st_a,  e.st);
            chk({e.tag, "_x"},     e.is_b ? x_b   : x_a,   e.x);
            chk({e.tag, "_hit"},   e.is_b ? hit_b : hit_a, e.hit);
            chk({e.tag, "_blk"},   e.is_b ? blk_b : blk_a, e.blk);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        sample();
        frame_tick = 1'b0;
    endtask

    task automatic set_box(input int x1, input int x2, input logic act);
        ox1 = 10'(x1); ox2 = 10'(x2); oy1 = 10'd60; oy2 = 10'd80; oact = act;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0;
        {bl_a, br_a, ba_a, bl_b, br_b, ba_b} = '0;
        hx1 = 10'd20; hx2 = 10'd40; hy1 = 10'd50; hy2 = 10'd90;
        set_box(30, 60, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        xa = A_START; xb = B_START;
        exp_a("reset_a", 4'd0, 1'b0, 1'b0);
        exp_b("reset_b", 4'd0);
        rst = 1'b0;
        sample();

        // back into the left clamp
        bl_a = 1'b1; xa = 0;
        exp_a("clamp_back", 4'd2, 1'b0, 1'b0); tick();
        exp_a("clamp_hold", 4'd2, 1'b0, 1'b0); tick();
        br_a = 1'b1;
        exp_a("both_dirs", 4'd0, 1'b0, 1'b0); tick();
        {bl_a, br_a} = '0;

        // neutral attack with the button held throughout
        ba_a = 1'b1;
        for (int i = 0; i < 4; i++) begin exp_a("atk_startup", 4'd3, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 2; i++) begin exp_a("atk_active",  4'd4, 1'b0, 1'b0); tick(); end
        for (int i = 0; i < 8; i++) begin exp_a("atk_recov",   4'd5, 1'b0, 1'b0); tick(); end
        exp_a("atk_done", 4'd0, 1'b0, 1'b0); tick();
        exp_a("atk_no_retrigger", 4'd0, 1'b0, 1'b0); tick();
        ba_a = 1'b0;
        exp_a("atk_release", 4'd0, 1'b0, 1'b0); tick();

        // hit during startup, overlap kept for part of the stun
        ba_a = 1'b1;
        exp_a("atk_again", 4'd3, 1'b0, 1'b0); tick();
        ba_a = 1'b0;
        set_box(30, 60, 1'b1);
        exp_a("hit_startup", 4'd9, 1'b1, 1'b0); tick();
        exp_a("hit_pulse_clear", 4'd9, 1'b0, 1'b0); sample();
        for (int i = 1; i < 16; i++) begin
            if (i == 10) oact = 1'b0;
            exp_a("hitstun", 4'd9, 1'b0, 1'b0); tick();
        end
        exp_a("hitstun_done", 4'd0, 1'b0, 1'b0); tick();

        // block from Idle with back held
        bl_a = 1'b1; oact = 1'b1;
        exp_a("block", 4'd10, 1'b0, 1'b1); tick();
        bl_a = 1'b0; oact = 1'b0;
        exp_a("block_pulse_clear", 4'd10, 1'b0, 1'b0); sample();
        for (int i = 1; i < 10; i++) begin exp_a("blockstun", 4'd10, 1'b0, 1'b0); tick(); end
        exp_a("blockstun_done", 4'd0, 1'b0, 1'b0); tick();

        // boxes touching at x edge are not an overlap
        set_box(40, 70, 1'b1);
        exp_a("edge_touch", 4'd0, 1'b0, 1'b0); tick();
        set_box(30, 60, 1'b0);

        // walk forward into the right clamp
        br_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            xa = (xa + 2 > XMAX) ? XMAX : xa + 2;
            exp_a("move_fwd", 4'd1, 1'b0, 1'b0); tick();
        end
        br_a = 1'b0;

        // mirrored directional attack: fwd is btn_left
        bl_b = 1'b1; ba_b = 1'b1;
        for (int i = 0; i < 6;  i++) begin exp_b("dir_startup", 4'd6); tick(); end
        for (int i = 0; i < 3;  i++) begin exp_b("dir_active",  4'd7); tick(); end
        for (int i = 0; i < 12; i++) begin exp_b("dir_recov",   4'd8); tick(); end
        bl_b = 1'b0; ba_b = 1'b0;
        exp_b("dir_done", 4'd0); tick();

        // mirrored movement direction
        bl_b = 1'b1; xb = B_START - 2;
        exp_b("mirror_fwd", 4'd1); tick();
        bl_b = 1'b0; br_b = 1'b1; xb = B_START;
        exp_b("mirror_back", 4'd2); tick();
        br_b = 1'b0;
        exp_b("mirror_idle", 4'd0); tick();

        // reset in directional recovery, with a tick on the same edge
        bl_b = 1'b1; ba_b = 1'b1;
        for (int i = 0; i < 6; i++) begin exp_b("dir2_startup", 4'd6); tick(); end
        for (int i = 0; i < 3; i++) begin exp_b("dir2_active",  4'd7); tick(); end
        for (int i = 0; i < 5; i++) begin exp_b("dir2_recov",   4'd8); tick(); end
        rst = 1'b1; frame_tick = 1'b1;
        xa = A_START; xb = B_START;
        exp_b("rst_recov_b", 4'd0);
        exp_a("rst_recov_a", 4'd0, 1'b0, 1'b0);
        sample();
        rst = 1'b0; frame_tick = 1'b0;
        {bl_b, ba_b} = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
